// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns one command at a time into a single AXI4-Lite
// write (AW/W/B) or read (AR/R) and returns the result on a valid/ready port.
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    // command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    // response port
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    timeout_err,
    // AXI4-Lite master
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
    } state_t;

    state_t                    state_q;
    logic                      cmd_ready_q;
    logic                      awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic                      rsp_valid_q, rsp_write_q;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [1:0]                rsp_resp_q;
    logic                      timeout_q;
    logic [CNT_W-1:0]          wait_q;

    logic aw_pend_d, w_pend_d, waiting_d;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^cmd_addr[1:0];

    always_comb begin
        aw_pend_d = awvalid_q & ~M_AXI_AWREADY;
        w_pend_d  = wvalid_q  & ~M_AXI_WREADY;
        waiting_d = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                    (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            timeout_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            // The slave is never abandoned; the counter only flags a stall.
            if (waiting_d && wait_q != CNT_MAX) begin
                wait_q <= wait_q + CNT_W'(1);
                if (wait_q == CNT_LAST) timeout_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        rsp_write_q <= cmd_write;
                        timeout_q   <= 1'b0;
                        wait_q      <= '0;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end
                S_WR: begin
                    awvalid_q <= aw_pend_d;
                    wvalid_q  <= w_pend_d;
                    if (!aw_pend_d && !w_pend_d) begin
                        bready_q <= 1'b1;
                        wait_q   <= '0;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= M_AXI_BRESP;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        wait_q      <= '0;
                        state_q     <= S_RSP;
                    end
                end
                S_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        rsp_valid_q <= 1'b1;
                        wait_q      <= '0;
                        state_q     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign timeout_err   = timeout_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: behavioural register slave, scoreboard
// queue of expected responses, and a monitor that checks each response handshake.
module tb_axil_cmd_master;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]   WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;

    axil_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
        .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
        .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
        .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
        .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always_ff @(posedge ACLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    logic        awready_en = 1'b1, wready_en = 1'b1, arready_en = 1'b1, bstall = 1'b0;
    logic [1:0]  slv_bresp = 2'b00;
    logic [31:0] mem [4];
    logic        aw_got, w_got, bvalid_q, rvalid_q;
    logic [AW-1:0] aw_a;
    logic [31:0] w_d, rdata_q;
    logic [3:0]  w_s;
    logic [1:0]  bresp_q;
    logic        aw_now, w_now;
    logic [AW-1:0] aw_addr_now;
    logic [31:0] w_d_now;
    logic [3:0]  w_s_now;

    assign AWREADY = awready_en & ~aw_got;
    assign WREADY  = wready_en & ~w_got;
    assign ARREADY = arready_en & ~rvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = 2'b00;

    assign aw_now      = aw_got | (AWVALID & AWREADY);
    assign w_now       = w_got  | (WVALID & WREADY);
    assign aw_addr_now = aw_got ? aw_a : AWADDR;
    assign w_d_now     = w_got ? w_d : WDATA;
    assign w_s_now     = w_got ? w_s : WSTRB;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
            aw_a <= '0; w_d <= '0; w_s <= '0; rdata_q <= '0; bresp_q <= 2'b00;
            for (int k = 0; k < 4; k++) mem[k] <= '0;
        end else begin
            if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_a <= AWADDR; end
            if (WVALID && WREADY) begin w_got <= 1'b1; w_d <= WDATA; w_s <= WSTRB; end
            if (aw_now && w_now && !bvalid_q && !bstall) begin
                bvalid_q <= 1'b1;
                bresp_q  <= slv_bresp;
                mem[aw_addr_now[3:2]] <= merge(mem[aw_addr_now[3:2]], w_d_now, w_s_now);
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (bvalid_q && BREADY) bvalid_q <= 1'b0;
            if (ARVALID && ARREADY) begin rvalid_q <= 1'b1; rdata_q <= mem[ARADDR[3:2]]; end
            if (rvalid_q && RREADY) rvalid_q <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;

    always @(negedge ACLK) begin
        if (!ARESET && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e_mon = sb_q.pop_front();
                chk("rsp_write", 64'(rsp_write), 64'(e_mon.wr));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e_mon.rdata));
                chk("rsp_resp",  64'(rsp_resp),  64'(e_mon.resp));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int acc = 0;  // cycle count value right after the accepting edge

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_rd,
                         input logic [1:0] exp_resp, input bit push);
        int n = 0;
        exp_t e;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
        if (!cmd_ready) chk("cmd_ready_wait_expired", 64'd0, 64'd1);
        if (push) begin
            e.wr = wr; e.rdata = exp_rd; e.resp = exp_resp;
            sb_q.push_back(e);
        end
        acc = cyc + 1;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    // lat = edges from acceptance to the first edge that samples rsp_valid=1
    task automatic wait_rsp(output int lat);
        int n = 0;
        while (!rsp_valid && n < 100) begin @(negedge ACLK); n++; end
        if (!rsp_valid) chk("rsp_valid_wait_expired", 64'd0, 64'd1);
        lat = cyc + 1 - acc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (rsp_valid && n < 100) begin @(negedge ACLK); n++; end
        if (rsp_valid) chk("rsp_drain_wait_expired", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int first;
        bit arv_ok;

        // reset state
        @(negedge ACLK); @(negedge ACLK);
        chk("reset_outputs", 64'({cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, timeout_err,
                                  AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
        chk("prot_tied", 64'({AWPROT, ARPROT}), 64'd0);

        // write sweep, low address bits deliberately non-zero
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, AW'(i*4 + i), 32'(i + 1), 4'hF, 32'd0, 2'b00, 1'b1);
            chk("wr_aw_w_valid", 64'({AWVALID, WVALID}), 64'h3);
            chk("wr_awaddr", 64'(AWADDR), 64'(i*4));
            chk("wr_wdata", 64'(WDATA), 64'(i + 1));
            wait_rsp(lat);
            chk("wr_latency", 64'(lat), 64'd3);
            @(negedge ACLK);
            chk("cmd_ready_return", 64'(cmd_ready), 64'd1);
            wait_done();
        end
        // read back
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, AW'(i*4), 32'd0, 4'h0, 32'(i + 1), 2'b00, 1'b1);
            chk("rd_arvalid", 64'({ARVALID, AWVALID}), 64'h2);
            chk("rd_araddr", 64'(ARADDR), 64'(i*4));
            wait_rsp(lat);
            chk("rd_latency", 64'(lat), 64'd3);
            wait_done();
        end

        // channel skew: WREADY withheld
        wready_en = 1'b0;
        issue(1'b1, 4'h8, 32'hA5A5_0003, 4'hF, 32'd0, 2'b00, 1'b1);
        chk("skew_both_valid", 64'({AWVALID, WVALID}), 64'h3);
        @(negedge ACLK);
        chk("skew_aw_drop", 64'(AWVALID), 64'd0);
        for (int k = 0; k < 5; k++) begin
            chk("skew_w_hold", 64'({WVALID, BREADY, WDATA}), 64'({1'b1, 1'b0, 32'hA5A5_0003}));
            if (k < 4) @(negedge ACLK);
        end
        wready_en = 1'b1;
        @(negedge ACLK);
        chk("skew_bready", 64'({WVALID, BREADY}), 64'h1);
        wait_rsp(lat);
        wait_done();

        // response backpressure
        issue(1'b1, 4'h8, 32'hDEAD_BEEF, 4'hF, 32'd0, 2'b00, 1'b1);
        wait_rsp(lat); wait_done();
        rsp_ready = 1'b0;
        issue(1'b0, 4'h8, 32'd0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b1);
        wait_rsp(lat);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold", 64'({rsp_valid, cmd_ready, AWVALID, ARVALID, rsp_rdata}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF}));
            @(negedge ACLK);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_done();
        issue(1'b0, 4'h8, 32'd0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b1);
        wait_rsp(lat); wait_done();

        // error pass-through
        slv_bresp = 2'b10;
        issue(1'b1, 4'h4, 32'h0000_0055, 4'hF, 32'd0, 2'b10, 1'b1);
        wait_rsp(lat);
        chk("slverr_no_timeout", 64'(timeout_err), 64'd0);
        wait_done();
        slv_bresp = 2'b00;

        // timeout with ARREADY withheld
        arready_en = 1'b0;
        issue(1'b0, 4'h0, 32'd0, 4'h0, 32'd1, 2'b00, 1'b1);
        first = -1;
        arv_ok = 1'b1;
        for (int j = 0; j <= TMO + 5; j++) begin
            if (timeout_err && first < 0) first = j;
            if (!ARVALID) arv_ok = 1'b0;
            if (j < TMO + 5) @(negedge ACLK);
        end
        chk("timeout_cycle", 64'(first), 64'(TMO));
        chk("arvalid_held", 64'(arv_ok), 64'd1);
        arready_en = 1'b1;
        wait_rsp(lat);
        wait_done();
        chk("timeout_sticky", 64'(timeout_err), 64'd1);
        issue(1'b0, 4'h4, 32'd0, 4'h0, 32'h0000_0055, 2'b00, 1'b1);
        chk("timeout_cleared", 64'(timeout_err), 64'd0);
        wait_rsp(lat); wait_done();

        // reset while waiting for B
        bstall = 1'b1;
        issue(1'b1, 4'hC, 32'h0000_0099, 4'hF, 32'd0, 2'b00, 1'b0);
        begin
            int n = 0;
            while (!BREADY && n < 50) begin @(negedge ACLK); n++; end
        end
        chk("reached_wr_resp", 64'(BREADY), 64'd1);
        ARESET = 1'b1;
        #1;
        chk("reset_async_drop", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}), 64'd0);
        bstall = 1'b0;
        @(negedge ACLK); @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        chk("cmd_ready_low_at_release", 64'(cmd_ready), 64'd0);
        @(negedge ACLK);
        chk("cmd_ready_after_release", 64'({cmd_ready, rsp_valid}), 64'h2);
        issue(1'b1, 4'h0, 32'h0000_0007, 4'hF, 32'd0, 2'b00, 1'b1);
        wait_rsp(lat);
        chk("post_reset_latency", 64'(lat), 64'd3);
        wait_done();

        repeat (5) @(negedge ACLK);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite initiator that turns single-word command requests from internal logic (pitch-detection control and sequencer FSMs) into AXI4-Lite write or read transactions on a memory-mapped register slave such as the constant/register black-box IPs. It accepts one command at a time, drives the AW/W/B or AR/R channels to completion, and returns read data plus response code on a valid/ready response port. It is the initiator end of the same 32-bit AXI4-Lite register interface the slave IPs expose, and replaces the VIP master in system builds.

## Interface
- ADDR_WIDTH, 4: AXI address width (byte address; 4 bits covers four 32-bit registers)
- DATA_WIDTH, 32: data width; only 32 is supported
- TIMEOUT_CYCLES, 256: cycles spent waiting on the slave before timeout_err is set (must be ≥ 2)

- ACLK  in  1  clock; all logic is on its rising edge
- ARESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored and driven 0 on AWADDR/ARADDR
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- timeout_err  out  1  sticky timeout flag
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels. AWPROT and ARPROT are tied to 3'b000.

## Operation
- States: IDLE, WR (AW and W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr/wdata/wstrb/write and clear timeout_err.
  - Go to WR with AWVALID=WVALID=1, or to RD_ADDR with ARVALID=1.
- WR: AWVALID and WVALID are independent.
  - Each drops on the cycle after its own handshake.
  - Either order, or both in the same cycle, is legal.
  - When both channels are done, go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID&BREADY, capture BRESP, set rsp_rdata=0, go to RSP, BREADY=0.
- RD_ADDR: on ARVALID&ARREADY, go to RD_DATA with ARVALID=0 and RREADY=1.
- RD_DATA: on RVALID&RREADY, capture RDATA/RRESP, go to RSP, RREADY=0.
- RSP: rsp_valid=1.
  - rsp_* fields are stable until rsp_valid&rsp_ready.
  - After that handshake, go to IDLE.
- Only one transaction is outstanding; cmd_ready=0 in every state except IDLE.
- Wait counter:
  - Resets to 0 on each state entry.
  - Increments every cycle in WR, WR_RESP, RD_ADDR or RD_DATA.
  - Saturates at TIMEOUT_CYCLES; reaching it sets timeout_err.
  - The transaction is not abandoned: the block keeps waiting, because dropping VALID is not legal AXI.
  - timeout_err clears only on the next command acceptance or on reset.
- SLVERR/DECERR responses are passed through in rsp_resp; they do not set timeout_err.

## Timing
- Reset (async assert; synchronous release on ACLK), all outputs 0:
  - state=IDLE.
  - cmd_ready, rsp_valid, all AXI VALID/READY outputs, rsp_rdata, rsp_resp, rsp_write, timeout_err, wait counter.
  - cmd_ready rises the first cycle after ARESET deasserts.
- All AXI outputs are registered. No combinational path from any input to any output.
- Command accepted at edge N → AWVALID/WVALID or ARVALID high from cycle N+1.
- Zero-wait slave, write: AW/W handshake at edge N+1, BREADY high N+2, B handshake at edge N+2, rsp_valid high N+3. Command-to-response = 3 cycles.
- Zero-wait slave, read: AR handshake at edge N+1, RREADY high N+2, R handshake at edge N+2, rsp_valid high N+3.
- If rsp_ready=1 at N+3, cmd_ready returns at N+4. Back-to-back throughput is one command per 4 cycles.
- VALID, once asserted, stays high with ADDR/DATA/STRB stable until its handshake.
- Reset mid-transaction: all VALIDs drop immediately (async), and no response is produced. The slave is assumed to be reset in the same domain.

## Test plan
- Write sweep: write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, wstrb=0xF, against a zero-wait slave. Expect each rsp_resp=OKAY, rsp_rdata=0, rsp_valid exactly 3 cycles after acceptance. Then read the four addresses back and expect rsp_rdata 0x1..0x4.
- Channel skew: slave holds WREADY low 5 cycles and AWREADY 0. Expect AWVALID to drop after 1 cycle, WVALID to stay high with WDATA stable until the handshake, and BREADY to rise only after both handshakes.
- Response backpressure: rsp_ready low 10 cycles after a read of 0x8 returning 0xDEADBEEF. Expect rsp_valid held with rsp_rdata stable, cmd_ready=0 throughout, cmd_valid ignored.
- Error pass-through: slave returns BRESP=SLVERR on a write to 0x4. Expect rsp_resp=2'b10 and timeout_err=0.
- Timeout: ARREADY held low for TIMEOUT_CYCLES+5. Expect timeout_err=1 at the TIMEOUT_CYCLES-th wait cycle and ARVALID still high. Release ARREADY; expect normal completion, then the next command clears timeout_err.
- Reset during WR_RESP: assert ARESET. Expect all VALID/READY outputs 0 in the same cycle, no rsp_valid, and cmd_ready=1 one cycle after release.
